ts_pkt_ingress: RTL
===================

// Module: ts_pkt_ingress
// PURPOSE
// - Upstream feeder of the TS descrambler. Locks to 188-byte TS packets on a byte stream.
// - Writes each packet into one half of a 512x8 ping-pong packet RAM.
// - Extracts the 13-bit PID and matches it against a programmable PID table.
// - Per completed packet, emits an end-of-packet strobe with find flag, 12-bit index and buffer half.
// - The descrambler reads the packet from the RAM read port.
// PARAMETERS
// - PID_NUM  8    number of PID table entries (1..16)
// - PKT_LEN  188  TS packet length in bytes
// PORTS
// - clk            in   1   system clock
// - rstn           in   1   asynchronous active-low reset
// - ts_i_valid     in   1   input byte valid
// - ts_i_data      in   8   input byte
// - ts_i_sop       in   1   first byte of packet; qualified by ts_i_valid
// - cfg_wren       in   1   PID table write strobe
// - cfg_waddr      in   4   PID table entry; entries >= PID_NUM are ignored
// - cfg_wdata      in   26  {valid[25], pid[24:12], index[11:0]}
// - buf_wren       out  1   packet RAM write enable
// - buf_waddr      out  9   {half, byte_cnt[7:0]}
// - buf_wdata      out  8   packet RAM write data
// - ts_eop         out  1   one-cycle end-of-packet strobe
// - ts_pid_find    out  1   PID matched for the last packet
// - ts_pid_index   out  12  matched entry index, post-modified (see below)
// - ts_buffer_h    out  1   RAM half holding the last completed packet
// - err_cnt        out  16  malformed-packet counter, saturating
// BEHAVIOUR
// Reset:
// - All outputs are 0.
// - State is HUNT. Write half is 0. PID table is all invalid.
// FSM:
// - HUNT -> PKT on (valid & sop & data==8'h47). The byte is written at byte_cnt=0.
// - HUNT: a sop with data!=8'h47 increments err_cnt and stays in HUNT. Non-sop bytes are ignored.
// - PKT: each valid byte is written at byte_cnt+1.
// - PKT: at byte_cnt==PKT_LEN-1 -> DONE.
// - PKT: a valid & sop arriving early aborts the packet:
//   - err_cnt increments; no eop; the half does not toggle.
//   - If that byte is 8'h47 it restarts the packet at byte_cnt=0; otherwise -> HUNT.
// - DONE lasts one cycle:
//   - ts_eop=1; pid_find, index and buffer_h update in the same cycle.
//   - The write half toggles; then -> HUNT.
//   - A valid byte arriving during DONE is evaluated as if in HUNT.
// Write port:
// - buf_wren/buf_waddr/buf_wdata are registered. A write appears 1 cycle after its input byte.
// - Gaps in ts_i_valid are allowed; byte_cnt advances only on valid.
// PID extraction:
// - pid = {byte1[4:0], byte2}. tei = byte1[7]. tsc = byte3[7:6].
// - Table compare is registered on byte 2.
// - Multiple matches: the lowest entry wins.
// - Result = matched & ~tei.
// Index modification:
// - ts_pid_index = entry index, with bit7 forced 0 when tsc==2'b00 (clear packet, no descramble).
// - No match: ts_pid_find=0 and ts_pid_index=0.
// Hold and timing:
// - ts_pid_find, ts_pid_index and ts_buffer_h hold until the next ts_eop.
// - ts_eop asserts 1 cycle after the last buf_wren of the packet.
// - The downstream consumer must finish reading a half within one packet time. No backpressure.
// PID table writes:
// - A cfg write takes effect the next cycle.
// - A packet whose byte-2 compare coincides with the write uses the old entry.
// Counter and reset:
// - err_cnt saturates at 16'hFFFF.
// - Reset mid-packet discards the partial packet; no eop is issued.
// TESTING
// - T1: entry0={1,13'h0100,12'h085}; one packet with PID 0x100, tsc=2'b10
//   -> 188 writes at addr 0..187; ts_eop; find=1, index=12'h085, buffer_h=0.
// - T2: two back-to-back packets on entry0
//   -> second packet written at 256..443; buffer_h=1.
// - T3: packet with tsc=2'b00 -> index=12'h005. Same packet with tei=1 -> find=0, index=0.
// - T4: sop at byte 100 with 8'h47 -> err_cnt=1; no eop; restart at addr 0; then a full packet completes normally.
// - T5: entries 2 and 5 both hold PID 0x200 -> index from entry 2.
//   cfg write to entry 2 in the byte-2 cycle -> old value is used.
// - T6: rstn low at byte 50, then release and send a full packet
//   -> outputs 0 during reset; first eop with buffer_h=0; err_cnt=0.

Source files
------------

// File: rtl/ts_pkt_ingress.sv
// TS packet ingress: locks to 188-byte packets, fills a ping-pong packet RAM and
// matches each packet's PID against a programmable table for the descrambler.
module ts_pkt_ingress #(
   parameter int PID_NUM = 8,
   parameter int PKT_LEN = 188
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ts_i_valid,
   input  logic [7:0]  ts_i_data,
   input  logic        ts_i_sop,
   input  logic        cfg_wren,
   input  logic [3:0]  cfg_waddr,
   input  logic [25:0] cfg_wdata,
   output logic        buf_wren,
   output logic [8:0]  buf_waddr,
   output logic [7:0]  buf_wdata,
   output logic        ts_eop,
   output logic        ts_pid_find,
   output logic [11:0] ts_pid_index,
   output logic        ts_buffer_h,
   output logic [15:0] err_cnt
);

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_PKT  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_r;
   logic [7:0]  cnt_r;
   logic        half_r;
   logic        tei_r;
   logic [4:0]  pid_hi_r;
   logic [1:0]  tsc_r;
   logic        hit_r;
   logic [11:0] hit_idx_r;

   logic        tbl_vld_r [PID_NUM];
   logic [12:0] tbl_pid_r [PID_NUM];
   logic [11:0] tbl_idx_r [PID_NUM];

   logic        is_sync_s;
   logic        bad_sop_s;
   logic        hunt_half_s;
   logic [7:0]  cnt_inc_s;
   logic [12:0] pid_s;
   logic        hit_s;
   logic [11:0] hit_idx_s;
   logic        find_s;
   logic [11:0] idx_mod_s;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Byte classification and result shaping
   always_comb begin
      is_sync_s   = ts_i_valid & ts_i_sop & (ts_i_data == 8'h47);
      bad_sop_s   = ts_i_valid & ts_i_sop & (ts_i_data != 8'h47);
      // During DONE the half has not toggled yet, so a new packet starts in the other half
      hunt_half_s = (state_r == ST_DONE) ? ~half_r : half_r;
      cnt_inc_s   = cnt_r + 8'd1;
      pid_s       = {pid_hi_r, ts_i_data};
      find_s      = hit_r & ~tei_r;
      // Clear packets (tsc==00) drop bit 7 so the descrambler passes them through
      idx_mod_s   = (tsc_r == 2'b00) ? {hit_idx_r[11:8], 1'b0, hit_idx_r[6:0]} : hit_idx_r;
   end

   // PID table lookup; descending scan so the lowest matching entry wins
   always_comb begin
      hit_s     = 1'b0;
      hit_idx_s = 12'd0;
      for (int e = PID_NUM - 1; e >= 0; e--) begin
         hit_s     = (tbl_vld_r[e] && (tbl_pid_r[e] == pid_s)) ? 1'b1 : hit_s;
         hit_idx_s = (tbl_vld_r[e] && (tbl_pid_r[e] == pid_s)) ? tbl_idx_r[e] : hit_idx_s;
      end
   end

   // PID table storage; out-of-range entries never match an index and are dropped
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int e = 0; e < PID_NUM; e++) begin
            tbl_vld_r[e] <= 1'b0;
            tbl_pid_r[e] <= 13'd0;
            tbl_idx_r[e] <= 12'd0;
         end
      end else begin
         for (int e = 0; e < PID_NUM; e++) begin
            if (cfg_wren && (cfg_waddr == 4'(e))) begin
               tbl_vld_r[e] <= cfg_wdata[25];
               tbl_pid_r[e] <= cfg_wdata[24:12];
               tbl_idx_r[e] <= cfg_wdata[11:0];
            end
         end
      end
   end

   // Packet lock FSM with registered RAM write port and end-of-packet results
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_HUNT;
         cnt_r        <= 8'd0;
         half_r       <= 1'b0;
         tei_r        <= 1'b0;
         pid_hi_r     <= 5'd0;
         tsc_r        <= 2'b00;
         hit_r        <= 1'b0;
         hit_idx_r    <= 12'd0;
         buf_wren     <= 1'b0;
         buf_waddr    <= 9'd0;
         buf_wdata    <= 8'd0;
         ts_eop       <= 1'b0;
         ts_pid_find  <= 1'b0;
         ts_pid_index <= 12'd0;
         ts_buffer_h  <= 1'b0;
         err_cnt      <= 16'd0;
      end else begin
         buf_wren <= 1'b0;
         ts_eop   <= 1'b0;
         case (state_r)
            ST_HUNT, ST_DONE: begin
               if (state_r == ST_DONE) begin
                  ts_eop       <= 1'b1;
                  ts_pid_find  <= find_s;
                  ts_pid_index <= find_s ? idx_mod_s : 12'd0;
                  ts_buffer_h  <= half_r;
                  half_r       <= ~half_r;
               end
               if (is_sync_s) begin
                  buf_wren  <= 1'b1;
                  buf_waddr <= {hunt_half_s, 8'd0};
                  buf_wdata <= ts_i_data;
                  cnt_r     <= 8'd0;
                  state_r   <= ST_PKT;
               end else begin
                  if (bad_sop_s) begin
                     err_cnt <= sat_inc(err_cnt);
                  end
                  state_r <= ST_HUNT;
               end
            end
            ST_PKT: begin
               if (ts_i_valid && ts_i_sop) begin
                  err_cnt <= sat_inc(err_cnt);
                  if (ts_i_data == 8'h47) begin
                     buf_wren  <= 1'b1;
                     buf_waddr <= {half_r, 8'd0};
                     buf_wdata <= ts_i_data;
                     cnt_r     <= 8'd0;
                  end else begin
                     state_r <= ST_HUNT;
                  end
               end else if (ts_i_valid) begin
                  buf_wren  <= 1'b1;
                  buf_waddr <= {half_r, cnt_inc_s};
                  buf_wdata <= ts_i_data;
                  cnt_r     <= cnt_inc_s;
                  if (cnt_inc_s == 8'd1) begin
                     tei_r    <= ts_i_data[7];
                     pid_hi_r <= ts_i_data[4:0];
                  end
                  if (cnt_inc_s == 8'd2) begin
                     hit_r     <= hit_s;
                     hit_idx_r <= hit_idx_s;
                  end
                  if (cnt_inc_s == 8'd3) begin
                     tsc_r <= ts_i_data[7:6];
                  end
                  if (cnt_inc_s == 8'(PKT_LEN - 1)) begin
                     state_r <= ST_DONE;
                  end
               end
            end
            default: begin
               state_r <= ST_HUNT;
            end
         endcase
      end
   end

endmodule
